servo_pwm_multi: RTL and testbench

Parametrised multi-channel driver for continuous-rotation servos. It generalises the single-channel two-button servo driver with N independent channels, an internal microsecond prescaler, a configurable PWM frame, and per-frame slew-rate limiting so the motors never step from stop to full speed. It sits between the tracking FSM, which supplies per-channel CW/CCW/enable commands, and the servo pins; one instance drives the frame motor and the panel motor.

---
 rtl/servo_pwm_multi.sv | 148 ++++++++++++++
 tb/tb_servo_pwm_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel continuous-rotation servo driver.
// One shared microsecond prescaler and PWM frame counter feed N channels.
// Each channel has a direction decoder, a target and current pulse width
// latched only at frame boundaries, and a slew limiter so the width never
// moves by more than RAMP_US per frame.
module servo_pwm_multi #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned CLK_DIV   = 100,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned STOP_US   = 1500,
  parameter int unsigned DELTA_US  = 200,
  parameter int unsigned RAMP_US   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   cw,
  input  logic [N_CH-1:0]   ccw,
  output logic [N_CH-1:0]   servo,
  output logic [2*N_CH-1:0] dir,
  output logic [N_CH-1:0]   at_target,
  output logic              frame
);

  localparam int unsigned PS_W  = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = $clog2(PERIOD_US);

  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PERIOD_US - 1);
  localparam logic [CNT_W-1:0] W_STOP     = CNT_W'(STOP_US);
  localparam logic [CNT_W-1:0] W_CW       = CNT_W'(STOP_US - DELTA_US);
  localparam logic [CNT_W-1:0] W_CCW      = CNT_W'(STOP_US + DELTA_US);
  localparam logic [CNT_W-1:0] W_RAMP     = CNT_W'(RAMP_US);

  // Map a registered direction code to its pulse width in microseconds.
  function automatic logic [CNT_W-1:0] dir_width(input logic [1:0] d);
    case (d)
      2'b01:   return W_CW;
      2'b10:   return W_CCW;
      default: return W_STOP;
    endcase
  endfunction

  // Move cur toward tgt by at most RAMP_US; snaps onto tgt when closer, so it
  // never overshoots. RAMP_US of zero means an immediate step.
  function automatic logic [CNT_W-1:0] ramp_step(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] diff;
    diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    if (RAMP_US == 0) return tgt;
    if (32'(diff) <= RAMP_US) return tgt;
    return (tgt > cur) ? (cur + W_RAMP) : (cur - W_RAMP);
  endfunction

  logic [PS_W-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               frame_q, frame_d;
  logic [N_CH-1:0]    en_q, en_d;
  logic [N_CH-1:0]    servo_q, servo_d;
  logic [2*N_CH-1:0]  dir_q, dir_d;
  logic [CNT_W-1:0]   cur_q    [N_CH];
  logic [CNT_W-1:0]   cur_d    [N_CH];
  logic [CNT_W-1:0]   target_q [N_CH];
  logic [CNT_W-1:0]   target_d [N_CH];
  logic               tick;
  logic               boundary;

  // Shared timebase: microsecond prescaler and frame counter.
  always_comb begin
    tick        = (presc_q == PS_LAST);
    boundary    = tick && (frame_cnt_q == FRAME_LAST);
    presc_d     = tick ? '0 : (presc_q + PS_W'(1));
    frame_cnt_d = frame_cnt_q;
    if (tick) begin
      frame_cnt_d = boundary ? '0 : (frame_cnt_q + CNT_W'(1));
    end
    // FRAME is high during the cycle whose closing edge wraps the frame.
    frame_d     = (presc_d == PS_LAST) && (frame_cnt_d == FRAME_LAST);
  end

  // Per-channel decode, boundary latching, slew limiting and pulse compare.
  always_comb begin
    dir_d   = '0;
    en_d    = en_q;
    servo_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cur_d[i]    = cur_q[i];
      target_d[i] = target_q[i];
    end
    for (int i = 0; i < N_CH; i++) begin
      if (cw[i] && !ccw[i]) begin
        dir_d[2*i +: 2] = 2'b01;
      end else if (ccw[i] && !cw[i]) begin
        dir_d[2*i +: 2] = 2'b10;
      end
      if (boundary) begin
        // The boundary sees the direction registered before this edge, so a
        // command arriving on the FRAME cycle waits one more frame.
        en_d[i]     = en[i];
        target_d[i] = dir_width(dir_q[2*i +: 2]);
        cur_d[i]    = en[i] ? ramp_step(cur_q[i], target_d[i]) : W_STOP;
      end
      // Compare against next-state values so the registered output rises on
      // the same edge that wraps the frame counter.
      servo_d[i] = en_d[i] && (frame_cnt_d < cur_d[i]);
    end
  end

  // State registers; reset also clears the PWM outputs asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      frame_cnt_q <= '0;
      frame_q     <= 1'b0;
      en_q        <= '0;
      servo_q     <= '0;
      dir_q       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i]    <= W_STOP;
        target_q[i] <= W_STOP;
      end
    end else begin
      presc_q     <= presc_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
      en_q        <= en_d;
      servo_q     <= servo_d;
      dir_q       <= dir_d;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i]    <= cur_d[i];
        target_q[i] <= target_d[i];
      end
    end
  end

  // Status: width has settled on the latched target.
  always_comb begin
    at_target = '0;
    for (int i = 0; i < N_CH; i++) begin
      at_target[i] = (cur_q[i] == target_q[i]);
    end
  end

  assign servo = servo_q;
  assign dir   = dir_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi. Expected pulse widths are pushed to a
// scoreboard when a pulse starts; a monitor measures each frame window and
// pops/compares at the next FRAME. A second instance runs with RAMP_US=0.
module tb_servo_pwm_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] en, cw, ccw;
  logic [1:0] servo, at_target, servo_z, at_target_z;
  logic [3:0] dir, dir_z;
  logic       frame, frame_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    w0;
    int    w1;
    int    z0;
  } exp_t;

  exp_t sb[$];

  servo_pwm_multi #(
    .N_CH(2), .CLK_DIV(2), .PERIOD_US(100), .STOP_US(30), .DELTA_US(10), .RAMP_US(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cw(cw), .ccw(ccw),
    .servo(servo), .dir(dir), .at_target(at_target), .frame(frame)
  );

  servo_pwm_multi #(
    .N_CH(2), .CLK_DIV(2), .PERIOD_US(100), .STOP_US(30), .DELTA_US(10), .RAMP_US(0)
  ) u_dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .cw(cw), .ccw(ccw),
    .servo(servo_z), .dir(dir_z), .at_target(at_target_z), .frame(frame_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int w0, input int w1, input int z0);
    exp_t e;
    e.tag = tag;
    e.w0  = w0;
    e.w1  = w1;
    e.z0  = z0;
    sb.push_back(e);
  endtask

  // Returns at #1 after the edge that closes the FRAME cycle (pulse start).
  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame && cyc < 400);
    chk("frame_seen", 32'(frame), 1);
    @(posedge clk);
    #1;
  endtask

  // Pulse-width monitor: counts high samples per frame window.
  int cnt0, cnt1, cntz;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      cnt0 = 0;
      cnt1 = 0;
      cntz = 0;
    end else begin
      cnt0 += 32'(servo[0]);
      cnt1 += 32'(servo[1]);
      cntz += 32'(servo_z[0]);
      if (frame) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("%s_ch0", e.tag), cnt0, e.w0);
          chk($sformatf("%s_ch1", e.tag), cnt1, e.w1);
          chk($sformatf("%s_z0", e.tag), cntz, e.z0);
        end
        cnt0 = 0;
        cnt1 = 0;
        cntz = 0;
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    en    = 2'b11;
    cw    = 2'b00;
    ccw   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_servo", 32'(servo), 0);
    chk("rst_servo_z", 32'(servo_z), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_at_target", 32'(at_target), 3);
    chk("rst_frame", 32'(frame), 0);

    // Idle
    rst_n = 1'b1;
    wait_frame(cyc);
    chk("first_frame_latency", cyc, 200);
    push("idle1", 60, 60, 60);
    wait_frame(cyc);
    chk("frame_period", cyc, 200);
    chk("idle_dir", 32'(dir), 0);
    chk("idle_at_target", 32'(at_target), 3);
    push("idle2", 60, 60, 60);

    // Ramp to CW on channel 0
    cw = 2'b01;
    chk("dir_before_edge", 32'(dir), 0);
    @(posedge clk);
    #1;
    chk("dir_cw", 32'(dir), 1);
    wait_frame(cyc);
    push("cw1", 52, 60, 40);
    chk("cw1_at_target", 32'(at_target), 2);
    chk("cw1_at_target_z", 32'(at_target_z), 3);
    wait_frame(cyc);
    push("cw2", 44, 60, 40);
    chk("cw2_at_target", 32'(at_target), 2);
    wait_frame(cyc);
    push("cw3", 40, 60, 40);
    chk("cw3_at_target", 32'(at_target), 3);
    wait_frame(cyc);
    push("cw4", 40, 60, 40);

    // Both requests -> stop, then CCW
    ccw = 2'b01;
    @(posedge clk);
    #1;
    chk("dir_both", 32'(dir), 0);
    wait_frame(cyc);
    push("both1", 48, 60, 60);
    wait_frame(cyc);
    push("both2", 56, 60, 60);
    wait_frame(cyc);
    push("both3", 60, 60, 60);
    chk("both3_at_target", 32'(at_target), 3);
    cw = 2'b00;
    wait_frame(cyc);
    push("ccw1", 68, 60, 80);
    chk("ccw1_at_target", 32'(at_target), 2);
    chk("ccw1_at_target_z", 32'(at_target_z), 3);
    wait_frame(cyc);
    push("ccw2", 76, 60, 80);
    wait_frame(cyc);
    push("ccw3", 80, 60, 80);

    // Mid-frame command on channel 1
    wait_frame(cyc);
    push("mid1", 80, 60, 80);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_servo_high", 32'(servo), 3);
    ccw = 2'b11;
    @(posedge clk);
    #1;
    chk("mid_dir", 32'(dir), 10);
    wait_frame(cyc);
    push("mid2", 80, 68, 80);

    // Enable gating on channel 0
    wait_frame(cyc);
    push("en1", 80, 76, 80);
    repeat (20) @(posedge clk);
    #1;
    en = 2'b10;
    @(posedge clk);
    #1;
    chk("en_drop_servo", 32'(servo), 3);
    chk("en_drop_servo_z", 32'(servo_z[0]), 1);
    wait_frame(cyc);
    push("en2", 0, 80, 0);
    cw  = 2'b01;
    ccw = 2'b10;
    wait_frame(cyc);
    push("en3", 0, 80, 0);
    chk("en3_at_target", 32'(at_target), 2);
    en = 2'b11;
    wait_frame(cyc);
    push("en4", 52, 80, 40);
    wait_frame(cyc);

    // Reset mid-pulse
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_servo", 32'(servo), 3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_servo", 32'(servo), 0);
    chk("async_rst_servo_z", 32'(servo_z), 0);
    chk("async_rst_dir", 32'(dir), 0);
    chk("async_rst_at_target", 32'(at_target), 3);
    chk("async_rst_frame", 32'(frame), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun_dir", 32'(dir), 9);
    wait_frame(cyc);
    chk("rerun_frame_latency", cyc, 199);
    push("rr1", 52, 68, 40);
    wait_frame(cyc);
    push("rr2", 44, 76, 40);
    wait_frame(cyc);
    push("rr3", 40, 80, 40);
    wait_frame(cyc);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
